// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with a TX FIFO on the MEM bus.
// Revision : 1.0
// ============================================================================
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] dataW,
    input  logic        MemRW,
    output logic        hit,
    output logic [31:0] dataR,
    output logic        tx,
    output logic        tx_busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
    localparam logic [1:0] c_OFF_STATUS  = 2'd1;
    localparam logic [1:0] c_OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] c_OFF_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Bus decode
    logic [1:0]         w_off;
    logic               w_wr;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [3:0]         w_cnt_status;
    logic [31:0]        w_status;
    logic               w_unused_bits;

    // Register file
    logic               r_enable;
    logic               r_ovf;
    logic [15:0]        r_baud;

    // FIFO
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         w_head;

    // Serializer
    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [15:0]        r_div;
    logic [15:0]        w_div_nxt;
    logic [15:0]        r_bitcnt;
    logic [15:0]        w_bitcnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic               w_bit_done;
    logic               r_tx;
    logic               r_busy;

    assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = addr[3:2];
    assign w_wr       = hit && MemRW;
    assign w_push_req = w_wr && (w_off == c_OFF_TXDATA);
    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    // Room is judged on the count at the start of the cycle; a same-cycle pop never helps.
    assign w_push     = w_push_req && !w_full;
    assign w_head     = r_mem[r_rptr];

    assign w_unused_bits = ^{addr[1:0], dataW[31:16]};

    // ------------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b1;
            r_ovf    <= 1'b0;
            r_baud   <= DEFAULT_DIV;
        end else begin
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_wr && (w_off == c_OFF_BAUDDIV)) begin
                r_baud <= dataW[15:0];
            end
            if (w_wr && (w_off == c_OFF_CTRL)) begin
                r_enable <= dataW[0];
                if (dataW[1]) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= dataW[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (c_CNT_W > 4) begin : g_cnt_sat
            assign w_cnt_status = (r_count > c_CNT_W'(15)) ? 4'hF : r_count[3:0];
        end else if (c_CNT_W == 4) begin : g_cnt_direct
            assign w_cnt_status = r_count;
        end else begin : g_cnt_pad
            assign w_cnt_status = {{(4 - c_CNT_W){1'b0}}, r_count};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_div    <= w_div_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign w_bit_done = (r_bitcnt == r_div);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_div_nxt    = r_div;
        w_bitcnt_nxt = r_bitcnt;
        w_idx_nxt    = r_idx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable && !w_empty) begin
                    // The divider is shadowed here so BAUDDIV writes never disturb a live frame.
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_head;
                    w_div_nxt    = r_baud;
                    w_bitcnt_nxt = '0;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_bitcnt_nxt = '0;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line and busy flag follow the state one cycle later, giving the store-to-start latency of two edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE);
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    assign w_status = {24'd0, w_cnt_status, r_ovf, r_busy, w_empty, w_full};

    always_comb begin
        dataR = 32'd0;
        if (hit) begin
            case (w_off)
                c_OFF_TXDATA:  dataR = 32'd0;
                c_OFF_STATUS:  dataR = w_status;
                c_OFF_BAUDDIV: dataR = {16'd0, r_baud};
                c_OFF_CTRL:    dataR = {31'd0, r_enable};
                default:       dataR = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Scoreboard bench for mmio_uart_tx; a line monitor decodes frames.
// Revision : 1.0
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] c_BASE    = 32'h0000_2000;
    localparam logic [31:0] c_TXDATA  = c_BASE + 32'h0;
    localparam logic [31:0] c_STATUS  = c_BASE + 32'h4;
    localparam logic [31:0] c_BAUDDIV = c_BASE + 32'h8;
    localparam logic [31:0] c_CTRL    = c_BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic        MemRW;
    logic        hit;
    logic [31:0] dataR;
    logic        tx;
    logic        tx_busy;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;

    // {div[15:0], byte[7:0]} per expected frame
    logic [23:0] sb [$];
    bit          mon_active  = 1'b0;
    bit          gap_en      = 1'b0;
    int          prev_start  = -1;
    int          exp_period  = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (c_BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .dataW   (dataW),
        .MemRW   (MemRW),
        .hit     (hit),
        .dataR   (dataR),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        dataW = d;
        MemRW = 1'b1;
        @(posedge clk);
        #1;
        MemRW = 1'b0;
        addr  = 32'd0;
        dataW = 32'd0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        MemRW = 1'b0;
        #1;
        check_eq(tag, dataR, exp);
        addr  = 32'd0;
    endtask

    task automatic send(input logic [7:0] b, input logic [15:0] div);
        sb.push_back({div, b});
        wr(c_TXDATA, {24'd0, b});
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active || tx_busy !== 1'b0) && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drain_done", 32'(n < max_cyc), 32'd1);
    endtask

    // Line monitor: decodes every frame and compares it with the scoreboard head.
    initial begin : monitor
        logic [23:0] item;
        logic [9:0]  frame;
        logic [7:0]  rx;
        int          div;
        int          bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                if (gap_en && prev_start >= 0) begin
                    check_eq("frame_period", 32'(cyc - prev_start), 32'(exp_period));
                end
                prev_start = cyc;
                check_eq("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() == 0) begin
                    for (int i = 0; i < 5000 && tx !== 1'b1; i++) @(negedge clk);
                end else begin
                    item    = sb.pop_front();
                    div     = int'(item[23:8]);
                    frame   = {1'b1, item[7:0], 1'b0};
                    rx      = 8'd0;
                    bad     = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        for (int c = 0; c <= div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst === 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (tx !== frame[b]) bad++;
                                if (c == 0 && b >= 1 && b <= 8) rx[b-1] = tx;
                            end
                        end
                    end
                    if (!aborted) begin
                        check_eq("rx_byte", {24'd0, rx}, {24'd0, item[7:0]});
                        check_eq("bit_timing", 32'(bad), 32'd0);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int busy_cnt;
        int low_cnt;
        rst   = 1'b1;
        addr  = 32'd0;
        dataW = 32'd0;
        MemRW = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
        check_reg("rst_status", c_STATUS, 32'h0000_0002);
        check_reg("rst_baud", c_BAUDDIV, 32'd433);
        check_reg("rst_ctrl", c_CTRL, 32'd1);
        check_reg("rd_txdata", c_TXDATA, 32'd0);
        addr = c_STATUS;
        #1;
        check_eq("hit_in", {31'd0, hit}, 32'd1);

        // 2: single frame, latency and busy length; upper BAUDDIV bits are dropped
        @(negedge clk);
        wr(c_BAUDDIV, 32'hABCD_0003);
        check_reg("baud_mask", c_BAUDDIV, 32'd3);
        send(8'hA5, 16'd3);
        @(negedge clk);
        check_eq("lat_k0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_eq("lat_k1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_eq("lat_k2", {31'd0, tx}, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        check_eq("busy_len", 32'(busy_cnt), 32'd40);
        drain(200);

        // 3: overflow with sender disabled, then burst at DIV=0
        wr(c_BAUDDIV, 32'd0);
        wr(c_CTRL, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) sb.push_back({16'd0, 8'(i)});
            wr(c_TXDATA, 32'(i));
        end
        check_reg("ovf_status", c_STATUS, 32'h0000_0089);
        check_reg("ctrl_off", c_CTRL, 32'd0);
        prev_start = -1;
        exp_period = 11;
        gap_en     = 1'b1;
        wr(c_CTRL, 32'd1);
        drain(500);
        gap_en = 1'b0;
        repeat (30) @(negedge clk);

        // 4: overflow clear, push at count 7 during a live frame
        #1;
        wr(c_CTRL, 32'd3);
        check_reg("ctrl_after_clr", c_CTRL, 32'd1);
        check_reg("status_clr", c_STATUS, 32'h0000_0002);
        wr(c_BAUDDIV, 32'd3);
        prev_start = -1;
        exp_period = 41;
        gap_en     = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 16'd3);
        send(8'h55, 16'd3);
        check_reg("full_status", c_STATUS, 32'h0000_0085);
        drain(2000);
        gap_en = 1'b0;

        // 5: divider change mid-frame applies from the next frame
        #1;
        sb.push_back({16'd3, 8'h3C});
        wr(c_TXDATA, 32'h3C);
        sb.push_back({16'd7, 8'hC3});
        wr(c_TXDATA, 32'hC3);
        wr(c_BAUDDIV, 32'd7);
        check_reg("baud7", c_BAUDDIV, 32'd7);
        drain(500);

        // 6: reset in DATA with three bytes queued; out-of-window store
        #1;
        sb.push_back({16'd7, 8'hE1});
        wr(c_TXDATA, 32'hE1);
        wr(c_TXDATA, 32'hE2);
        wr(c_TXDATA, 32'hE3);
        wr(c_TXDATA, 32'hE4);
        repeat (20) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_tx", {31'd0, tx}, 32'd1);
        check_eq("mrst_busy", {31'd0, tx_busy}, 32'd0);
        check_reg("mrst_status", c_STATUS, 32'h0000_0002);
        check_reg("mrst_baud", c_BAUDDIV, 32'd433);
        addr = c_BASE + 32'h10;
        #1;
        check_eq("hit_out", {31'd0, hit}, 32'd0);
        check_eq("dataR_out", dataR, 32'd0);
        @(negedge clk);
        wr(c_BASE + 32'h10, 32'h77);
        check_reg("out_status", c_STATUS, 32'h0000_0002);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check_eq("quiet_line", 32'(low_cnt), 32'd0);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
